tm1638: RTL and testbench

- Byte-level serial master for a TM1638 LED/key driver chip.
- Sits between a host (8-bit bidirectional parallel bus with latch/rw/busy handshake) and the chip's 2-wire clock/data pins (sclk, dio).
- Shifts one byte per transaction, LSB first: either writes a host byte out on dio_out, or reads a byte from dio_in and returns it on the shared data bus.
- STB (chip select) framing is handled outside this block.

---
 rtl/tm1638.sv | 159 +++++++++++++++
 tb/tb_tm1638.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tm1638.sv
// Byte-level serial master for a TM1638 LED/key driver: shifts one byte LSB first
// over sclk/dio, either writing a host byte or reading a byte back onto the host bus.
module tm1638 #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_latch,
   inout  wire  [7:0] data,
   input  logic       rw,
   output logic       busy,
   output logic       sclk,
   output logic       dio_out,
   input  logic       dio_in,
   output logic [1:0] o_dbg_state
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DIV_W-1:0]   r_div;
   logic [DIV_W-1:0]   w_div_nxt;
   logic [2:0]         r_bit;
   logic [2:0]         w_bit_nxt;
   logic [2:0]         w_bit_inc;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_nxt;
   logic [7:0]         r_rdata;
   logic [7:0]         w_rdata_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               r_sclk;
   logic               w_sclk_nxt;
   logic               r_dio;
   logic               w_dio_nxt;
   logic               r_dir;
   logic               w_dir_nxt;
   logic               w_div_done;

   // Host bus drive follows rw live; the captured direction only steers the serial side.
   assign data        = rw ? 8'bz : r_rdata;
   assign busy        = r_busy;
   assign sclk        = r_sclk;
   assign dio_out     = r_dio;
   assign o_dbg_state = r_state;
   assign w_div_done  = (r_div == DIV_LAST);
   assign w_bit_inc   = r_bit + 3'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div   <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_rdata <= 8'h00;
         r_busy  <= 1'b0;
         r_sclk  <= 1'b1;
         r_dio   <= 1'b1;
         r_dir   <= 1'b0;
      end else begin
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_rdata <= w_rdata_nxt;
         r_busy  <= w_busy_nxt;
         r_sclk  <= w_sclk_nxt;
         r_dio   <= w_dio_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_rdata_nxt = r_rdata;
      w_busy_nxt  = r_busy;
      w_sclk_nxt  = r_sclk;
      w_dio_nxt   = r_dio;
      w_dir_nxt   = r_dir;

      case (r_state)
         IDLE: begin
            if (data_latch) begin
               w_state_nxt = LOW;
               w_busy_nxt  = 1'b1;
               w_sclk_nxt  = 1'b0;
               w_bit_nxt   = 3'd0;
               w_div_nxt   = '0;
               w_dir_nxt   = rw;
               if (rw) begin
                  w_shift_nxt = data;
                  w_dio_nxt   = data[0];
               end else begin
                  w_dio_nxt   = 1'b1;
               end
            end
         end

         LOW: begin
            if (w_div_done) begin
               w_div_nxt   = '0;
               w_state_nxt = HIGH;
               w_sclk_nxt  = 1'b1;
               // Read data is taken on the same edge that raises sclk.
               if (!r_dir) begin
                  w_shift_nxt[r_bit] = dio_in;
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end

         HIGH: begin
            if (w_div_done) begin
               w_div_nxt = '0;
               if (r_bit != 3'd7) begin
                  w_bit_nxt   = w_bit_inc;
                  w_state_nxt = LOW;
                  w_sclk_nxt  = 1'b0;
                  if (r_dir) begin
                     w_dio_nxt = r_shift[w_bit_inc];
                  end
               end else begin
                  w_state_nxt = IDLE;
                  w_busy_nxt  = 1'b0;
                  w_dio_nxt   = 1'b1;
                  if (!r_dir) begin
                     w_rdata_nxt = r_shift;
                  end
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tm1638.sv
// Scoreboard bench for tm1638: drivers push expected {is_write, byte} entries,
// a negedge monitor rebuilds each serial byte and checks it when busy falls.
module tb_tm1638;

   logic       clk = 1'b0;
   logic       rst;
   logic       data_latch;
   logic       rw;
   logic       dio_in;
   logic [7:0] tb_data;
   wire  [7:0] data;
   logic       busy;
   logic       sclk;
   logic       dio_out;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   assign data = rw ? tb_data : 8'bz;

   tm1638 #(.CLK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_latch (data_latch),
      .data       (data),
      .rw         (rw),
      .busy       (busy),
      .sclk       (sclk),
      .dio_out    (dio_out),
      .dio_in     (dio_in),
      .o_dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic       prev_sclk = 1'b1;
   logic       prev_busy = 1'b0;
   int         nbits = 0;
   int         blen  = 0;
   logic       rd_dio_bad = 1'b0;
   logic [7:0] wbyte = 8'h00;
   logic [8:0] e;

   always @(negedge clk) begin
      if (rst) begin
         nbits      = 0;
         blen       = 0;
         rd_dio_bad = 1'b0;
         prev_busy  = 1'b0;
         prev_sclk  = 1'b1;
      end else begin
         if (busy) blen++;
         if (busy && !prev_sclk && sclk) begin
            if (nbits < 8) wbyte[nbits[2:0]] = dio_out;
            if (!rw && dio_out !== 1'b1) rd_dio_bad = 1'b1;
            nbits++;
         end
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_txn", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("busy_len", blen, 32'd64);
               check("sclk_pulses", nbits, 32'd8);
               check("sclk_idle_high", sclk, 32'd1);
               check("dio_idle_high", dio_out, 32'd1);
               if (e[8]) begin
                  check("write_byte", wbyte, e[7:0]);
               end else begin
                  check("read_byte", data, e[7:0]);
                  check("read_dio_released", rd_dio_bad, 32'd0);
               end
            end
            nbits      = 0;
            blen       = 0;
            rd_dio_bad = 1'b0;
         end
         prev_busy = busy;
         prev_sclk = sclk;
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 32'd0);
      @(posedge clk);
   endtask

   task automatic start_write(input logic [7:0] b);
      @(negedge clk);
      rw         = 1'b1;
      tb_data    = b;
      data_latch = 1'b1;
      exp_q.push_back({1'b1, b});
      @(negedge clk);
      data_latch = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] b);
      start_write(b);
      wait_idle();
   endtask

   task automatic do_read(input logic [7:0] b);
      @(negedge clk);
      rw         = 1'b0;
      dio_in     = b[0];
      data_latch = 1'b1;
      exp_q.push_back({1'b0, b});
      @(negedge clk);
      data_latch = 1'b0;
      repeat (7) @(negedge clk);
      for (int k = 1; k < 8; k++) begin
         dio_in = b[k];
         if (k < 7) repeat (8) @(negedge clk);
      end
      wait_idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      rst        = 1'b1;
      data_latch = 1'b0;
      rw         = 1'b0;
      dio_in     = 1'b1;
      tb_data    = 8'h00;
      repeat (5) @(negedge clk);
      check("rst_busy", busy, 32'd0);
      check("rst_sclk", sclk, 32'd1);
      check("rst_dio", dio_out, 32'd1);
      check("rst_data", data, 32'h00);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 32'd0);
      check("post_rst_sclk", sclk, 32'd1);

      do_write(8'h40);
      do_write(8'hAA);
      repeat (36) @(negedge clk);
      do_write(8'h55);
      check("sclk_high_after_write", sclk, 32'd1);

      do_read(8'h55);
      do_read(8'hAA);
      do_write(8'h3C);
      rw = 1'b0;
      @(negedge clk);
      check("rdata_held", data, 32'hAA);

      // Second latch mid-transfer must be ignored.
      start_write(8'hC3);
      repeat (9) @(negedge clk);
      tb_data    = 8'h5A;
      data_latch = 1'b1;
      @(negedge clk);
      data_latch = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      check("no_queued_txn", busy, 32'd0);

      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) do_write(b);
         else do_read(b);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      // Reset in the middle of bit 3 of a write.
      start_write(8'hF0);
      repeat (26) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_busy", busy, 32'd0);
      check("midrst_sclk", sclk, 32'd1);
      check("midrst_dio", dio_out, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_write(8'h96);
      do_read(8'h69);

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
